// File: rtl/code_loader_pkg.sv
// Shared types and constants for the code image loader.
package code_loader_pkg;

    // Image geometry: width in bits (multiple of 32) and capacity in bytes.
    localparam int CODE_BITS_DEFAULT = 65536;
    localparam int CODE_BYTES        = CODE_BITS_DEFAULT / 8;

    // Frame layout: two length bytes (big-endian), payload, one checksum byte.
    localparam int FRAME_LEN_HI_POS  = 0;
    localparam int FRAME_LEN_LO_POS  = 1;
    localparam int FRAME_HDR_BYTES   = 2;
    localparam int FRAME_TRL_BYTES   = 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        PAYLOAD = 3'd3,
        CHECK   = 3'd4,
        DONE    = 3'd5,
        ERROR   = 3'd6
    } load_state_t;

    // True in the states that consume host bytes.
    function automatic logic state_takes_bytes(input load_state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == PAYLOAD) || (s == CHECK);
    endfunction

endpackage

// File: rtl/code_image_store.sv
// Wide code image register with a synchronous clear and a single byte write port.
module code_image_store #(
    parameter int CODE_BITS = 65536,
    parameter int IDX_W     = $clog2(CODE_BITS / 8)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [7:0]           wr_data,
    output logic [CODE_BITS-1:0] image
);

    // Clear wins over a write; otherwise one byte lane is updated per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            image <= '0;
        end else if (clear) begin
            image <= '0;
        end else if (wr_en) begin
            image[{wr_idx, 3'b000} +: 8] <= wr_data;
        end
    end

endmodule

// File: rtl/code_loader.sv
// Loads a length/payload/checksum byte frame into the CPU code image and
// holds the CPU in reset until a verified image is present.
module code_loader
    import code_loader_pkg::*;
#(
    parameter int CODE_BITS = CODE_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_start,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    output logic [CODE_BITS-1:0] code,
    output logic                 cpu_reset,
    output logic                 load_done,
    output logic                 load_error,
    output logic [15:0]          bytes_loaded
);

    localparam int          IDX_W   = $clog2(CODE_BITS / 8);
    localparam logic [16:0] MAX_LEN = 17'(CODE_BITS / 8);

    load_state_t state_reg;
    logic [15:0] length_reg;
    logic [7:0]  acc_reg;
    logic [15:0] len_next;
    logic [15:0] loaded_next;
    logic [7:0]  check_sum;
    logic        accept;
    logic        wr_en;

    // Host may only hand over a byte in a framing state and never during a restart pulse.
    always_comb begin
        byte_ready  = state_takes_bytes(state_reg) && !load_start;
        accept      = byte_ready && byte_valid;
        wr_en       = accept && (state_reg == PAYLOAD);
        len_next    = {length_reg[15:8], byte_data};
        loaded_next = bytes_loaded + 16'd1;
        check_sum   = acc_reg + byte_data;
    end

    // Frame sequencing, length/checksum bookkeeping and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            length_reg   <= '0;
            acc_reg      <= '0;
            bytes_loaded <= '0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            cpu_reset    <= 1'b1;
        end else if (load_start) begin
            state_reg    <= LEN_HI;
            length_reg   <= '0;
            acc_reg      <= '0;
            bytes_loaded <= '0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            cpu_reset    <= 1'b1;
        end else if (accept) begin
            case (state_reg)
                LEN_HI: begin
                    length_reg[15:8] <= byte_data;
                    state_reg        <= LEN_LO;
                end
                LEN_LO: begin
                    length_reg[7:0] <= byte_data;
                    if ({1'b0, len_next} > MAX_LEN) begin
                        state_reg  <= ERROR;
                        load_error <= 1'b1;
                    end else if (len_next == 16'd0) begin
                        state_reg <= CHECK;
                    end else begin
                        state_reg <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    acc_reg      <= check_sum;
                    bytes_loaded <= loaded_next;
                    if (loaded_next == length_reg) begin
                        state_reg <= CHECK;
                    end
                end
                CHECK: begin
                    if (check_sum == 8'd0) begin
                        state_reg <= DONE;
                        load_done <= 1'b1;
                        cpu_reset <= 1'b0;
                    end else begin
                        state_reg  <= ERROR;
                        load_error <= 1'b1;
                    end
                end
                default: state_reg <= state_reg;
            endcase
        end
    end

    code_image_store #(
        .CODE_BITS (CODE_BITS),
        .IDX_W     (IDX_W)
    ) u_store (
        .clk     (clk),
        .reset   (reset),
        .clear   (load_start),
        .wr_en   (wr_en),
        .wr_idx  (bytes_loaded[IDX_W-1:0]),
        .wr_data (byte_data),
        .image   (code)
    );

endmodule
